// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the shared memory port and the arbiter.
// slave  : arbiter view (takes requests, drives the memory port and completions).
// master : environment view (pipeline stages plus memory model).
interface mem_port_arbiter_if;
   // Fetch port
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        if_stall;
   // Data port
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        d_stall;
   // Memory port
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_rvalid,
      output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata, mem_rvalid,
      input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data accesses.
// Data wins ties; a consecutive-grant counter forces a fetch after STARVE_LIMIT data grants.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus,
   output logic              busy,
   output logic              timeout_err
);
   localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e             state_q, state_d;
   logic               gnt_data_q, gnt_data_d;
   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;
   logic               mem_en_q, mem_en_d;
   logic               mem_we_q, mem_we_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic [3:0]         mem_wstrb_q, mem_wstrb_d;
   logic [31:0]        if_rdata_q, if_rdata_d;
   logic [31:0]        d_rdata_q, d_rdata_d;
   logic               if_valid_q, if_valid_d;
   logic               d_valid_q, d_valid_d;
   logic               busy_q, busy_d;
   logic               timeout_err_q, timeout_err_d;
   logic               tmo_fire;
   logic [31:0]        resp_data;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

   // Watchdog: counts WAIT cycles without a response, restarts on every entry to WAIT
   always_comb begin
      tmo_cnt_d = '0;
      tmo_fire  = 1'b0;
      if (state_q == StWait && !bus.mem_rvalid) begin
         if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            tmo_fire = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
         end
      end
   end

   // Watchdog counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_fire = 1'b0;
`endif

   // Next state, grant decision and registered output values
   always_comb begin
      state_d       = state_q;
      gnt_data_d    = gnt_data_q;
      starve_cnt_d  = starve_cnt_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_wstrb_d   = mem_wstrb_q;
      if_rdata_d    = if_rdata_q;
      d_rdata_d     = d_rdata_q;
      if_valid_d    = 1'b0;
      d_valid_d     = 1'b0;
      timeout_err_d = 1'b0;
      resp_data     = bus.mem_rvalid ? bus.mem_rdata : 32'hDEADBEEF;

      unique case (state_q)
         StIdle: begin
            if (bus.if_req || bus.d_req) begin
               state_d    = StIssue;
               gnt_data_d = bus.d_req &&
                            !(bus.if_req && starve_cnt_q == StarveW'(STARVE_LIMIT));
               if (gnt_data_d) begin
                  mem_we_d    = bus.d_we;
                  mem_addr_d  = bus.d_addr;
                  mem_wdata_d = bus.d_wdata;
                  mem_wstrb_d = bus.d_we ? bus.d_wstrb : 4'h0;
                  if (!bus.if_req) begin
                     starve_cnt_d = '0;
                  end else if (starve_cnt_q != StarveW'(STARVE_LIMIT)) begin
                     starve_cnt_d = starve_cnt_q + StarveW'(1);
                  end
               end else begin
                  mem_we_d     = 1'b0;
                  mem_addr_d   = bus.if_addr;
                  mem_wdata_d  = '0;
                  mem_wstrb_d  = 4'h0;
                  starve_cnt_d = '0;
               end
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (bus.mem_rvalid || tmo_fire) begin
               state_d       = StResp;
               timeout_err_d = tmo_fire;
               if (gnt_data_q) begin
                  d_valid_d = 1'b1;
                  // Stores leave d_rdata alone unless the watchdog reports an error
                  if (!mem_we_q || tmo_fire) begin
                     d_rdata_d = resp_data;
                  end
               end else begin
                  if_valid_d = 1'b1;
                  if_rdata_d = resp_data;
               end
            end
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      mem_en_d = (state_d == StIssue);
      busy_d   = (state_d != StIdle);
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         gnt_data_q    <= 1'b0;
         starve_cnt_q  <= '0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_wstrb_q   <= '0;
         if_rdata_q    <= '0;
         d_rdata_q     <= '0;
         if_valid_q    <= 1'b0;
         d_valid_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_data_q    <= gnt_data_d;
         starve_cnt_q  <= starve_cnt_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_wstrb_q   <= mem_wstrb_d;
         if_rdata_q    <= if_rdata_d;
         d_rdata_q     <= d_rdata_d;
         if_valid_q    <= if_valid_d;
         d_valid_q     <= d_valid_d;
         busy_q        <= busy_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_wstrb = mem_wstrb_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.d_valid   = d_valid_q;
   // Stalls follow the live request so a dropped request releases the stage at once
   assign bus.if_stall  = bus.if_req & ~if_valid_q;
   assign bus.d_stall   = bus.d_req & ~d_valid_q;
   assign busy          = busy_q;
   assign timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Define ARB_TIMEOUT_EN to expect the watchdog behaviour in the final hang test.
module tb_mem_port_arbiter;
   localparam int unsigned StarveLimit = 4;
   localparam int unsigned TmoCycles   = 16;

   logic clk;
   logic reset;
   logic busy;
   logic timeout_err;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(
      .STARVE_LIMIT   (StarveLimit),
      .TIMEOUT_CYCLES (TmoCycles)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned errors;
   int unsigned checks;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Transaction-level model state
   int unsigned cyc;
   int unsigned free_from;
   int unsigned en_cyc, rv_cyc, val_cyc;
   int unsigned starve_m;
   int          mode;        // 0 random, 1 both always requesting, 2 drain
   bit          active;
   bit          gnt_d_m;
   bit          if_wait, d_wait;
   logic        g_we;
   logic [31:0] g_addr, g_wdata, rsp_data, d_rdata_m;
   logic [3:0]  g_wstrb;
   bit          dut_log[$];  // 1 = data grant, taken from mem_addr[31]

   task automatic raise_if();
      bus.if_req  = 1'b1;
      bus.if_addr = {16'h0000, 14'($urandom), 2'b00};
   endtask

   task automatic raise_d();
      bus.d_req   = 1'b1;
      bus.d_we    = 1'($urandom);
      bus.d_addr  = {16'h8000, 14'($urandom), 2'b00};
      bus.d_wdata = $urandom;
      bus.d_wstrb = 4'($urandom);
   endtask

   // One cycle at the falling edge: check outputs, advance model, drive next inputs
   task automatic cycle_body();
      bit exp_en, exp_iv, exp_dv, exp_busy;
      exp_en   = active && cyc == en_cyc;
      exp_iv   = active && cyc == val_cyc && !gnt_d_m;
      exp_dv   = active && cyc == val_cyc && gnt_d_m;
      exp_busy = active && cyc >= en_cyc && cyc <= val_cyc;

      check_eq("mem_en", 32'(bus.mem_en), 32'(exp_en));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("if_valid", 32'(bus.if_valid), 32'(exp_iv));
      check_eq("d_valid", 32'(bus.d_valid), 32'(exp_dv));
      check_eq("if_stall", 32'(bus.if_stall), 32'(bus.if_req && !exp_iv));
      check_eq("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !exp_dv));
      check_eq("timeout_err", 32'(timeout_err), 32'd0);
      if (exp_en) begin
         check_eq("mem_we", 32'(bus.mem_we), 32'(g_we));
         check_eq("mem_addr", bus.mem_addr, g_addr);
         check_eq("mem_wstrb", 32'(bus.mem_wstrb), 32'(g_wstrb));
         if (g_we) check_eq("mem_wdata", bus.mem_wdata, g_wdata);
         dut_log.push_back(bus.mem_addr[31]);
         rv_cyc  = cyc + 1 + $urandom_range(0, 3);
         val_cyc = rv_cyc + 1;
      end
      if (exp_iv) check_eq("if_rdata", bus.if_rdata, rsp_data);
      if (exp_dv) begin
         check_eq("d_rdata", bus.d_rdata, g_we ? d_rdata_m : rsp_data);
         if (!g_we) d_rdata_m = rsp_data;
      end
      if (exp_iv || exp_dv) begin
         active    = 1'b0;
         free_from = cyc + 1;
         if (exp_iv) begin if_wait = 1'b0; bus.if_req = 1'b0; end
         else        begin d_wait  = 1'b0; bus.d_req  = 1'b0; end
      end

      // Memory responder; stray responses outside the wait window must be ignored
      if (active && cyc == rv_cyc) begin
         rsp_data       = $urandom;
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = rsp_data;
      end else if (active && cyc > en_cyc && cyc < rv_cyc) begin
         bus.mem_rvalid = 1'b0;
         bus.mem_rdata  = $urandom;
      end else begin
         bus.mem_rvalid = ($urandom_range(0, 3) == 0);
         bus.mem_rdata  = $urandom;
      end

      // Requesters
      if (mode == 1) begin
         if (!bus.if_req && !if_wait) raise_if();
         if (!bus.d_req && !d_wait) raise_d();
      end else if (mode == 0) begin
         if (!bus.if_req && !if_wait) begin
            if ($urandom_range(0, 2) == 0) raise_if();
         end else if (bus.if_req && $urandom_range(0, 15) == 0) begin
            bus.if_req = 1'b0;
         end
         if (!bus.d_req && !d_wait) begin
            if ($urandom_range(0, 1) == 0) raise_d();
         end else if (bus.d_req && $urandom_range(0, 15) == 0) begin
            bus.d_req = 1'b0;
         end
      end else begin
         if (bus.if_req && !if_wait) bus.if_req = 1'b0;
         if (bus.d_req && !d_wait) bus.d_req = 1'b0;
      end

      // Arbitration at the coming edge
      if (!active && cyc >= free_from && (bus.if_req || bus.d_req)) begin
         gnt_d_m = bus.d_req && !(bus.if_req && starve_m == StarveLimit);
         if (gnt_d_m) begin
            starve_m = bus.if_req ? ((starve_m < StarveLimit) ? starve_m + 1 : starve_m) : 0;
            g_we     = bus.d_we;
            g_addr   = bus.d_addr;
            g_wdata  = bus.d_wdata;
            g_wstrb  = bus.d_we ? bus.d_wstrb : 4'h0;
            d_wait   = 1'b1;
         end else begin
            starve_m = 0;
            g_we     = 1'b0;
            g_addr   = bus.if_addr;
            g_wdata  = '0;
            g_wstrb  = 4'h0;
            if_wait  = 1'b1;
         end
         active  = 1'b1;
         en_cyc  = cyc + 1;
         val_cyc = 32'hFFFF_FFFF;
      end
   endtask

   task automatic tick();
      cycle_body();
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
      check_eq({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      check_eq({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check_eq({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
      check_eq({tag, "_valids"}, 32'({bus.if_valid, bus.d_valid}), 32'd0);
      check_eq({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_tmo"}, 32'(timeout_err), 32'd0);
   endtask

   initial begin
      bit pat [10];
      pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      errors = 0; checks = 0;
      reset = 1'b1;
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
      bus.d_wdata = 0; bus.d_wstrb = 0; bus.mem_rdata = 0; bus.mem_rvalid = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      reset     = 1'b0;
      cyc       = 0;
      free_from = 0;
      active    = 0; if_wait = 0; d_wait = 0; starve_m = 0; d_rdata_m = '0;
      en_cyc    = 0; rv_cyc = 0; val_cyc = 0;

      // Both requesters held high from reset
      mode = 1;
      for (int i = 0; i < 300 && dut_log.size() < 10; i++) tick();
      check_eq("starve_len", 32'(dut_log.size() >= 10), 32'd1);
      for (int i = 0; i < 10 && i < dut_log.size(); i++) begin
         check_eq($sformatf("starve_seq%0d", i), 32'(dut_log[i]), 32'(pat[i]));
      end

      mode = 0;
      for (int i = 0; i < 3000; i++) tick();

      mode = 2;
      for (int i = 0; i < 200 && (active || if_wait || d_wait); i++) tick();
      check_eq("drained", 32'(active), 32'd0);

      // Reset asserted while waiting for memory, response arrives after release
      bus.mem_rvalid = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200;
      @(negedge clk);
      check_eq("rst_mid_en", 32'(bus.mem_en), 32'd1);
      check_eq("rst_mid_addr", bus.mem_addr, 32'h0000_0200);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_mid");
      bus.d_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_rvalid = 1'b0;
         check_eq("rst_after_valid", 32'({bus.if_valid, bus.d_valid}), 32'd0);
         check_eq("rst_after_busy", 32'(busy), 32'd0);
         check_eq("rst_after_en", 32'(bus.mem_en), 32'd0);
      end

      // Memory never answers a load
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         check_eq("hang_en", 32'(bus.mem_en), 32'(i == 1));
`ifdef ARB_TIMEOUT_EN
         check_eq("hang_busy", 32'(busy), 32'(i <= TmoCycles + 2));
         check_eq("hang_dvalid", 32'(bus.d_valid), 32'(i == TmoCycles + 2));
         check_eq("hang_tmo", 32'(timeout_err), 32'(i == TmoCycles + 2));
         if (i == TmoCycles + 2) begin
            check_eq("hang_rdata", bus.d_rdata, 32'hDEADBEEF);
            bus.d_req = 1'b0;
         end
`else
         check_eq("hang_busy", 32'(busy), 32'd1);
         check_eq("hang_dvalid", 32'(bus.d_valid), 32'd0);
         check_eq("hang_tmo", 32'(timeout_err), 32'd0);
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
